timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with interrupt.
// Three-register window at BASE: CTRL (+0), PRESET (+4), COUNT (+8, read-only).
// Optional macro TIMER_AUTORELOAD_EN enables MODE 01 (auto-reload); without it
// every count is one-shot and MODE reads back as 00.
// dbg_state exposes the FSM state (0 IDLE, 1 LOAD, 2 CNT, 3 INT).
// Bus handshake: a write is accepted at the rising edge where WE=1 and the
// address hits a writable register; reads are combinational with no wait state.
module timer_counter #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [29:0] BASE_WORD = BASE[31:2];

    state_t      state;
    state_t      state_next;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        irq_flag;
    logic        set_flag;
    logic        clr_flag;
    logic        clr_en;

    logic [29:0] word;
    logic        hit_ctrl;
    logic        hit_preset;
    logic        hit_count;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [1:0]  din_mode;
    logic        auto_reload;
    logic        en_now;

    assign word       = Addr[31:2];
    assign hit_ctrl   = (word == BASE_WORD);
    assign hit_preset = (word == BASE_WORD + 30'd1);
    assign hit_count  = (word == BASE_WORD + 30'd2);
    assign wr_ctrl    = WE & hit_ctrl;
    assign wr_preset  = WE & hit_preset;

`ifdef TIMER_AUTORELOAD_EN
    logic unused_bits;
    assign din_mode    = Din[2:1];
    assign unused_bits = ^{Addr[1:0], Din[31:4]};
`else
    logic unused_bits;
    assign din_mode    = 2'b00;
    assign unused_bits = ^{Addr[1:0], Din[31:4], Din[2:1]};
`endif

    assign auto_reload = (ctrl_mode == 2'b01);

    // A CTRL write on the same edge overrides the stored enable, so a disable
    // freezes COUNT at the value software saw, and a re-enable beats the
    // one-shot EN-clear in INT.
    assign en_now = wr_ctrl ? Din[0] : ctrl_en;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and counter/flag/enable control
    always_comb begin
        state_next = state;
        count_next = count;
        set_flag   = 1'b0;
        clr_flag   = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en_now) begin
                    state_next = IDLE;
                end else if (count == 32'd0) begin
                    state_next = INT;
                    set_flag   = 1'b1;
                end else begin
                    count_next = count - 32'd1;
                end
            end
            INT: begin
                if (auto_reload) begin
                    clr_flag   = 1'b1;
                    state_next = en_now ? LOAD : IDLE;
                end else begin
                    clr_en     = 1'b1;
                    state_next = (wr_ctrl && Din[0]) ? LOAD : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // COUNT register; only the FSM updates it, never the bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else begin
            count <= count_next;
        end
    end

    // Interrupt flag: any CTRL write clears it and takes priority over a set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl || clr_flag) begin
            irq_flag <= 1'b0;
        end else if (set_flag) begin
            irq_flag <= 1'b1;
        end
    end

    // CTRL register: CPU write wins over the one-shot EN-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= Din[0];
            ctrl_mode <= din_mode;
            ctrl_im   <= Din[3];
        end else if (clr_en) begin
            ctrl_en   <= 1'b0;
        end
    end

    // PRESET register; a write mid-count is picked up at the next LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= Din;
        end
    end

    // Combinational read mux, zero on a miss
    always_comb begin
        Dout = 32'd0;
        if (hit_ctrl) begin
            Dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
        end else if (hit_preset) begin
            Dout = preset;
        end else if (hit_count) begin
            Dout = count;
        end
    end

    assign IRQ       = irq_flag & ctrl_im;
    assign dbg_state = state;

endmodule
